// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator
//
// Sums a stream of signed products (from radix8_booth_multiplier) into a
// saturating accumulator, one group at a time. A group ends on the beat
// flagged in_last; the result is then held until downstream takes it.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous active-high reset
//   in_valid    in   1       in_product / in_last valid
//   in_ready    out  1       a beat is accepted this cycle when in_valid=1
//   in_product  in   PROD_W  signed product
//   in_last     in   1       final beat of the group
//   out_valid   out  1       group result held on out_acc/out_count/out_sat
//   out_ready   in   1       downstream consumes the result
//   out_acc     out  ACC_W   signed accumulated sum (running value outside HOLD)
//   out_count   out  CNT_W   beats accepted in the group, clamps at all-ones
//   out_sat     out  1       accumulator clamped at least once in the group
module booth_mac_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_product,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_sat
);

    if (ACC_W <= PROD_W) begin : g_width_check
        $error("booth_mac_accumulator: ACC_W must be greater than PROD_W");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sat;

    logic                    w_accept;
    logic                    w_release;
    logic signed [ACC_W:0]   w_prod_ext;
    logic signed [ACC_W:0]   w_sum;

    // One guard bit above the accumulator: the sum of two ACC_W-bit signed
    // values cannot overflow ACC_W+1 bits, so the top two bits disagreeing
    // is exactly the out-of-range condition.
    function automatic logic sum_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_sum(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1]) begin
            // Sign of the wide sum picks the rail.
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign w_prod_ext = {{(ACC_W + 1 - PROD_W){in_product[PROD_W-1]}}, in_product};
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
    assign w_accept   = in_valid && in_ready;
    assign w_release  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ACCUM;
                end
            end
            default: w_next = ACCUM;
        endcase
    end

    // Accumulator state; in HOLD no beat is accepted, so the values freeze
    // until the release handshake clears them.
    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_acc <= sat_sum(w_sum);
            r_cnt <= cnt_inc(r_cnt);
            r_sat <= r_sat | sum_ovf(w_sum);
        end
    end

    assign out_acc   = r_acc;
    assign out_count = r_cnt;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
module tb_booth_mac_accumulator;

    localparam int     PROD_W = 32;
    localparam int     ACC_W  = 34;
    localparam int     CNT_W  = 2;
    localparam longint AMAX   = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint AMIN   = -(longint'(1) <<< (ACC_W - 1));
    localparam int     CMAX   = (1 << CNT_W) - 1;
    localparam longint PMAX   = 64'sd2147483647;
    localparam longint PMIN   = -64'sd2147483648;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PROD_W-1:0] in_product;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]         out_count;
    logic                     out_sat;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state: plain integers, one flag for "result pending".
    longint m_acc  = 0;
    int     m_cnt  = 0;
    bit     m_sat  = 1'b0;
    bit     m_hold = 1'b0;

    always #5 clk = ~clk;

    booth_mac_accumulator #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_product(in_product),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a group is a running sum clamped to the ACC_W signed range,
    // a beat count clamped to CMAX, and a sticky clamp flag.
    always @(posedge clk) begin
        longint s;
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_hold = 1'b0;
        end else if (!m_hold) begin
            if (in_valid) begin
                s = m_acc + longint'(in_product);
                if (s > AMAX) begin s = AMAX; m_sat = 1'b1; end
                if (s < AMIN) begin s = AMIN; m_sat = 1'b1; end
                m_acc = s;
                m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
                if (in_last) m_hold = 1'b1;
            end
        end else if (out_ready) begin
            m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready",  longint'(in_ready),  longint'(!m_hold));
            chk("cyc_out_valid", longint'(out_valid), longint'(m_hold));
            chk("cyc_out_acc",   longint'(out_acc),   m_acc);
            chk("cyc_out_count", longint'(out_count), longint'(m_cnt));
            chk("cyc_out_sat",   longint'(out_sat),   longint'(m_sat));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input longint p, input bit last);
        in_valid   = 1'b1;
        in_product = p[PROD_W-1:0];
        in_last    = last;
        step();
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic chk_result(input string name, input longint acc, input int cnt, input bit sat);
        chk({name, "_valid"}, longint'(out_valid), 1);
        chk({name, "_ready"}, longint'(in_ready),  0);
        chk({name, "_acc"},   longint'(out_acc),   acc);
        chk({name, "_count"}, longint'(out_count), longint'(cnt));
        chk({name, "_sat"},   longint'(out_sat),   longint'(sat));
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, longint'(out_valid), 0);
        chk({name, "_ready"}, longint'(in_ready),  1);
        chk({name, "_acc"},   longint'(out_acc),   0);
        chk({name, "_count"}, longint'(out_count), 0);
        chk({name, "_sat"},   longint'(out_sat),   0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk_idle("reset");

        // Basic group: 6, then 0 (last); zero still counts as a beat.
        beat(6, 1'b0);
        beat(0, 1'b1);
        chk_result("basic", 6, 2, 1'b0);
        take();
        chk_idle("basic_clear");

        // Signed group, with out_ready high during ACCUM (must be ignored).
        out_ready = 1'b1;
        beat(64'sd1073741824, 1'b0);
        out_ready = 1'b0;
        beat(-6, 1'b1);
        chk_result("signed", 1073741818, 2, 1'b0);

        // Backpressure: input offered while holding must not be absorbed.
        in_valid = 1'b1; in_product = 32'sd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_result("bp_hold", 1073741818, 2, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0;
        chk_idle("bp_clear");

        // Positive clamp: 4*(2^31-1) still fits, the fifth beat clamps.
        for (int i = 0; i < 4; i++) beat(PMAX, 1'b0);
        chk("pos_nearmax_acc", longint'(out_acc), 64'sd8589934588);
        chk("pos_nearmax_sat", longint'(out_sat), 0);
        beat(PMAX, 1'b1);
        chk_result("pos_sat", AMAX, 3, 1'b1);
        take();

        // Negative: four beats of -2^31 land exactly on the minimum (no clamp).
        for (int i = 0; i < 4; i++) beat(PMIN, 1'b0);
        chk("neg_exact_acc", longint'(out_acc), -64'sd8589934592);
        chk("neg_exact_sat", longint'(out_sat), 0);
        beat(PMIN, 1'b1);
        chk_result("neg_sat", AMIN, 3, 1'b1);
        take();

        // Sticky flag does not leak into the next group; single-beat group.
        beat(5, 1'b1);
        chk_result("after_sat", 5, 1, 1'b0);
        take();

        // Count clamp at 3 with CNT_W=2, without setting sat.
        for (int i = 0; i < 4; i++) beat(1, 1'b0);
        beat(1, 1'b1);
        chk_result("cnt_clamp", 5, 3, 1'b0);
        take();

        // Reset mid-group discards the partial sum.
        beat(100, 1'b0);
        beat(200, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("mid_rst");
        beat(7, 1'b1);
        chk_result("mid_rst_grp", 7, 1, 1'b0);
        take();

        // Reset wins over a simultaneous accept.
        beat(50, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_product = 32'sd9; in_last = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0;
        chk_idle("rst_vs_accept");

        // Reset in HOLD, together with out_ready, drops the pending result.
        beat(3, 1'b1);
        chk_result("pre_hold_rst", 3, 1, 1'b0);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0;
        chk_idle("hold_rst");
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
